// File: rtl/spi_target_responder.sv
// SPI mode-0 target: oversampled SCK/CS_N/MOSI, MSB-first byte deserialiser,
// and a MISO serialiser fed from a one-deep TX buffer with a valid/ready handshake.
module spi_target_responder #(
    parameter int unsigned       DATA_W      = 8,
    parameter int unsigned       SYNC_STAGES = 2,
    parameter logic [DATA_W-1:0] DEFAULT_TX  = '1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              spi_sck_i,
    input  logic              spi_cs_n_i,
    input  logic              spi_mosi_i,
    output logic              spi_miso_o,
    output logic              spi_miso_oe,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              tx_underrun,
    output logic              frame_abort,
    output logic              busy
);

    localparam int unsigned CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] ACTIVE = 1'b1;

    logic [SYNC_STAGES-1:0] sck_sync_q;
    logic [SYNC_STAGES-1:0] cs_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic                   sck_dly_q;
    logic                   cs_dly_q;

    logic sck_s, cs_s, mosi_s;
    logic sck_rise, sck_fall, cs_rise, cs_fall;

    logic [0:0]        state_q, state_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DATA_W-2:0] rx_shift_q, rx_shift_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
    logic              miso_q, miso_d;
    logic              oe_q, oe_d;
    logic              underrun_q, underrun_d;
    logic              abort_q, abort_d;
    logic [DATA_W-1:0] buf_q, buf_d;
    logic              buf_full_q, buf_full_d;

    logic load;
    logic accept;

    // Input synchronisers; reset values match an idle bus (SCK low, CS_N high).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_sync_q  <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            sck_dly_q   <= 1'b0;
            cs_dly_q    <= 1'b1;
        end else begin
            sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], spi_sck_i};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n_i};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi_i};
            sck_dly_q   <= sck_sync_q[SYNC_STAGES-1];
            cs_dly_q    <= cs_sync_q[SYNC_STAGES-1];
        end
    end

    assign sck_s    = sck_sync_q[SYNC_STAGES-1];
    assign cs_s     = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
    assign sck_rise =  sck_s & ~sck_dly_q;
    assign sck_fall = ~sck_s &  sck_dly_q;
    assign cs_rise  =  cs_s  & ~cs_dly_q;
    assign cs_fall  = ~cs_s  &  cs_dly_q;

    assign accept = tx_valid & ~buf_full_q;

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        rx_shift_d = rx_shift_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        tx_shift_d = tx_shift_q;
        oe_d       = oe_q;
        underrun_d = 1'b0;
        abort_d    = 1'b0;
        buf_d      = buf_q;
        buf_full_d = buf_full_q;
        load       = 1'b0;

        case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    state_d   = ACTIVE;
                    bit_cnt_d = '0;
                    oe_d      = 1'b1;
                    load      = 1'b1;
                end
            end
            ACTIVE: begin
                // CS_N rising has priority over any SCK edge seen in the same cycle.
                if (cs_rise) begin
                    state_d   = IDLE;
                    oe_d      = 1'b0;
                    bit_cnt_d = '0;
                    abort_d   = (bit_cnt_q != '0);
                end else if (sck_rise) begin
                    rx_shift_d = {rx_shift_q[DATA_W-3:0], mosi_s};
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d  = '0;
                        rx_data_d  = {rx_shift_q, mosi_s};
                        rx_valid_d = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end else if (sck_fall) begin
                    if (bit_cnt_q != '0) begin
                        tx_shift_d = {tx_shift_q[DATA_W-2:0], 1'b0};
                    end else begin
                        load = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // An accept can only coincide with a load when the buffer is empty,
        // so the load takes DEFAULT_TX and the new word lands in the buffer.
        if (load) begin
            if (buf_full_q) begin
                tx_shift_d = buf_q;
                buf_full_d = 1'b0;
            end else begin
                tx_shift_d = DEFAULT_TX;
                underrun_d = 1'b1;
            end
        end
        if (accept) begin
            buf_d      = tx_data;
            buf_full_d = 1'b1;
        end

        miso_d = oe_d & tx_shift_d[DATA_W-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            rx_shift_q <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            tx_shift_q <= '0;
            miso_q     <= 1'b0;
            oe_q       <= 1'b0;
            underrun_q <= 1'b0;
            abort_q    <= 1'b0;
            buf_q      <= '0;
            buf_full_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            rx_shift_q <= rx_shift_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            tx_shift_q <= tx_shift_d;
            miso_q     <= miso_d;
            oe_q       <= oe_d;
            underrun_q <= underrun_d;
            abort_q    <= abort_d;
            buf_q      <= buf_d;
            buf_full_q <= buf_full_d;
        end
    end

    assign spi_miso_o  = miso_q;
    assign spi_miso_oe = oe_q;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign tx_ready    = ~buf_full_q;
    assign tx_underrun = underrun_q;
    assign frame_abort = abort_q;
    assign busy        = (state_q == ACTIVE);

endmodule

// File: tb/tb_spi_target_responder.sv
// Directed bench for spi_target_responder: a mode-0 master driven at clk/8
// with hand-computed expected bytes, pulse counts and reset values.
module tb_spi_target_responder;

    logic       clk;
    logic       rst_n;
    logic       sck;
    logic       cs_n;
    logic       mosi;
    logic       miso;
    logic       miso_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_underrun;
    logic       frame_abort;
    logic       busy;

    int n_cmp = 0;
    int n_err = 0;

    int rx_cnt = 0;
    int ur_cnt = 0;
    int ab_cnt = 0;
    logic [7:0] rx_log [0:63];

    spi_target_responder #(
        .DATA_W      (8),
        .SYNC_STAGES (2),
        .DEFAULT_TX  (8'hFF)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .spi_sck_i   (sck),
        .spi_cs_n_i  (cs_n),
        .spi_mosi_i  (mosi),
        .spi_miso_o  (miso),
        .spi_miso_oe (miso_oe),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .tx_underrun (tx_underrun),
        .frame_abort (frame_abort),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters sampled on the falling clock edge, away from DUT updates.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rx_valid) begin
                rx_log[rx_cnt % 64] = rx_data;
                rx_cnt = rx_cnt + 1;
            end
            if (tx_underrun) ur_cnt = ur_cnt + 1;
            if (frame_abort) ab_cnt = ab_cnt + 1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] d);
        int waited = 0;
        @(negedge clk);
        while (!tx_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        check("push_ready_wait", 32'(waited < 200), 32'd1);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic cs_low();
        @(negedge clk);
        cs_n = 1'b0;
        #80;
    endtask

    // One MSB-first word; with last set, CS_N rises together with the final SCK fall.
    task automatic xfer(input logic [7:0] mo, input bit last, output logic [7:0] mi);
        for (int i = 7; i >= 0; i--) begin
            mosi = mo[i];
            #40;
            mi[i] = miso;
            sck = 1'b1;
            #40;
            sck = 1'b0;
            if (last && i == 0) cs_n = 1'b1;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_miso"},     32'(miso),        32'd0);
        check({tag, "_oe"},       32'(miso_oe),     32'd0);
        check({tag, "_rx_data"},  32'(rx_data),     32'd0);
        check({tag, "_rx_valid"}, 32'(rx_valid),    32'd0);
        check({tag, "_tx_ready"}, 32'(tx_ready),    32'd1);
        check({tag, "_underrun"}, 32'(tx_underrun), 32'd0);
        check({tag, "_abort"},    32'(frame_abort), 32'd0);
        check({tag, "_busy"},     32'(busy),        32'd0);
    endtask

    initial begin
        logic [7:0] m0, m1, m2;
        int rx0, ur0, ab0;

        rst_n    = 1'b0;
        sck      = 1'b0;
        cs_n     = 1'b1;
        mosi     = 1'b0;
        tx_data  = 8'h00;
        tx_valid = 1'b0;
        #23;
        check_reset_outputs("rst");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // 1: empty buffer, receive A5, MISO shows default word, one underrun.
        rx0 = rx_cnt; ur0 = ur_cnt;
        cs_low();
        check("t1_oe_active", 32'(miso_oe), 32'd1);
        check("t1_busy",      32'(busy),    32'd1);
        xfer(8'hA5, 1'b1, m0);
        #80;
        check("t1_rx_data",  32'(rx_data),       32'hA5);
        check("t1_rx_count", 32'(rx_cnt - rx0),  32'd1);
        check("t1_miso",     32'(m0),            32'hFF);
        check("t1_underrun", 32'(ur_cnt - ur0),  32'd1);
        check("t1_oe_off",   32'(miso_oe),       32'd0);
        check("t1_miso_off", 32'(miso),          32'd0);
        check("t1_busy_off", 32'(busy),          32'd0);

        // 2: preloaded 3C comes out on MISO; buffer frees when loaded.
        rx0 = rx_cnt; ur0 = ur_cnt;
        push(8'h3C);
        check("t2_ready_full", 32'(tx_ready), 32'd0);
        cs_low();
        check("t2_ready_freed", 32'(tx_ready), 32'd1);
        xfer(8'h00, 1'b1, m0);
        #80;
        check("t2_miso",     32'(m0),           32'h3C);
        check("t2_rx_data",  32'(rx_data),      32'h00);
        check("t2_rx_count", 32'(rx_cnt - rx0), 32'd1);
        check("t2_underrun", 32'(ur_cnt - ur0), 32'd0);

        // 3: three back-to-back words in one frame; third TX word absent.
        rx0 = rx_cnt; ur0 = ur_cnt;
        push(8'h11);
        cs_low();
        push(8'h22);
        xfer(8'h81, 1'b0, m0);
        xfer(8'h42, 1'b0, m1);
        xfer(8'hE7, 1'b1, m2);
        #80;
        check("t3_miso0",    32'(m0), 32'h11);
        check("t3_miso1",    32'(m1), 32'h22);
        check("t3_miso2",    32'(m2), 32'hFF);
        check("t3_rx_count", 32'(rx_cnt - rx0), 32'd3);
        check("t3_rx0",      32'(rx_log[rx0 % 64]),       32'h81);
        check("t3_rx1",      32'(rx_log[(rx0 + 1) % 64]), 32'h42);
        check("t3_rx2",      32'(rx_log[(rx0 + 2) % 64]), 32'hE7);
        check("t3_underrun", 32'(ur_cnt - ur0), 32'd1);

        // 4: abort after a partial word, then a clean frame.
        rx0 = rx_cnt; ab0 = ab_cnt;
        cs_low();
        for (int i = 0; i < 5; i++) begin
            mosi = i[0];
            #40;
            sck = 1'b1;
            #40;
            sck = 1'b0;
        end
        #40;
        cs_n = 1'b1;
        #80;
        check("t4_abort",      32'(ab_cnt - ab0),  32'd1);
        check("t4_no_rx",      32'(rx_cnt - rx0),  32'd0);
        check("t4_oe_off",     32'(miso_oe),       32'd0);
        check("t4_rx_held",    32'(rx_data),       32'hE7);
        rx0 = rx_cnt; ab0 = ab_cnt;
        cs_low();
        xfer(8'h5A, 1'b1, m0);
        #80;
        check("t4_rx_data",    32'(rx_data),       32'h5A);
        check("t4_rx_count",   32'(rx_cnt - rx0),  32'd1);
        check("t4_no_abort",   32'(ab_cnt - ab0),  32'd0);

        // 5: asynchronous reset in the middle of a word, then a clean frame.
        push(8'h77);
        cs_low();
        for (int i = 0; i < 4; i++) begin
            mosi = 1'b1;
            #40;
            sck = 1'b1;
            #40;
            sck = 1'b0;
        end
        mosi = 1'b1;
        #40;
        sck = 1'b1;
        #13;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("t5_rst");
        sck  = 1'b0;
        cs_n = 1'b1;
        mosi = 1'b0;
        #50;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        rx0 = rx_cnt;
        cs_low();
        xfer(8'hC3, 1'b1, m0);
        #80;
        check("t5_rx_data",  32'(rx_data),      32'hC3);
        check("t5_rx_count", 32'(rx_cnt - rx0), 32'd1);
        check("t5_miso",     32'(m0),           32'hFF);

        // 6: SCK activity with CS_N high is ignored.
        push(8'hAB);
        rx0 = rx_cnt;
        for (int i = 0; i < 16; i++) begin
            mosi = ~mosi;
            #40;
            sck = ~sck;
            check("t6_oe_idle", 32'(miso_oe), 32'd0);
        end
        #80;
        check("t6_no_rx",     32'(rx_cnt - rx0), 32'd0);
        check("t6_ready",     32'(tx_ready),     32'd0);
        check("t6_busy",      32'(busy),         32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
